// File: rtl/seven_segment_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seven_segment_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DWELL = 2'd2
   } arb_state_t;

   localparam int DISP_W = 32;

   localparam logic BASE_HEX = 1'b0;
   localparam logic BASE_DEC = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set request strictly after last, wrapping.
module rr_priority_pick #(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [IW-1:0]   grant,
   output logic            any
);

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(last) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/seven_segment_arbiter.sv
// Shares one 8-digit seven-segment display among NREQ requesters,
// holding each granted value for at least DWELL_CYCLES cycles.
module seven_segment_arbiter
   import seven_segment_arbiter_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int DWELL_CYCLES = 50_000_000,
   localparam int IW = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DISP_W-1:0] req_data,
   input  logic [NREQ-1:0]        req_base,
   output logic [NREQ-1:0]        req_ready,
   output logic [DISP_W-1:0]      num_out,
   output logic                   base_sel,
   output logic [IW-1:0]          owner,
   output logic                   busy
);

   localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);
   localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

   arb_state_t state_q, state_d;

   logic [IW-1:0]     g_q, g_d;
   logic [IW-1:0]     last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   ready_d;
   logic [DISP_W-1:0] num_d;
   logic              base_d;
   logic [IW-1:0]     owner_d;
   logic              busy_d;

   logic [IW-1:0]     pick_g;
   logic              pick_any;

   logic [DISP_W-1:0] data_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*DISP_W +: DISP_W];
   end

   rr_priority_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req   (req_valid),
      .last  (last_q),
      .grant (pick_g),
      .any   (pick_any)
   );

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      ready_d = '0;
      num_d   = num_out;
      base_d  = base_sel;
      owner_d = owner;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               g_d     = pick_g;
               ready_d = NREQ'(1) << pick_g;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A requester that withdrew in its grant cycle is skipped
            // without touching the display or the fairness pointer.
            if (req_valid[g_q]) begin
               num_d   = data_arr[g_q];
               base_d  = req_base[g_q];
               owner_d = g_q;
               last_d  = g_q;
               cnt_d   = CNT_LOAD;
               state_d = ST_DWELL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DWELL: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         g_q       <= '0;
         last_q    <= LAST_RST;
         cnt_q     <= '0;
         req_ready <= '0;
         num_out   <= '0;
         base_sel  <= BASE_HEX;
         owner     <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         req_ready <= ready_d;
         num_out   <= num_d;
         base_sel  <= base_d;
         owner     <= owner_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Bench for seven_segment_arbiter: directed scenarios plus random
// traffic checked against a grant-timeline reference model.
module tb_seven_segment_arbiter;

   localparam int NREQ = 4;
   localparam int D    = 4;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*32-1:0] req_data = '0;
   logic [NREQ-1:0]   req_base = '0;
   logic [NREQ-1:0]   req_ready;
   logic [31:0]       num_out;
   logic              base_sel;
   logic [1:0]        owner;
   logic              busy;

   int checks = 0;
   int failures = 0;

   int c = 0;
   int grant_at, idle_at, pend_at;
   int mg, mlast;
   logic [31:0] e_num, p_num;
   logic        e_base, p_base;
   int          e_owner, p_owner;
   logic [NREQ-1:0] drop_next = '0;

   seven_segment_arbiter #(
      .NREQ         (NREQ),
      .DWELL_CYCLES (D)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_base  (req_base),
      .req_ready (req_ready),
      .num_out   (num_out),
      .base_sel  (base_sel),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, c);
      end
   endtask

   function automatic int rr_next(input logic [NREQ-1:0] v,
                                  input int from);
      for (int k = 1; k <= NREQ; k++)
         if (v[(from + k) % NREQ]) return (from + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [31:0] onehot(input int i);
      logic [31:0] one;
      one = 32'd1;
      return one << i;
   endfunction

   task automatic model_reset();
      e_num    = '0;
      e_base   = 1'b0;
      e_owner  = 0;
      mlast    = NREQ - 1;
      grant_at = -1;
      pend_at  = -1;
      idle_at  = c;
      drop_next = '0;
   endtask

   // Checks one cycle at the negedge, then advances the timeline model.
   task automatic tick();
      logic [31:0] exp_ready;
      @(negedge clk);
      if (c == pend_at) begin
         e_num   = p_num;
         e_base  = p_base;
         e_owner = p_owner;
      end
      exp_ready = (c == grant_at) ? onehot(mg) : 32'd0;
      chk("req_ready", 32'(req_ready), exp_ready);
      chk("busy", 32'(busy), 32'(c < idle_at));
      chk("num_out", num_out, e_num);
      chk("base_sel", 32'(base_sel), 32'(e_base));
      chk("owner", 32'(owner), 32'(e_owner));
      if (c == grant_at) begin
         if (req_valid[mg]) begin
            p_num   = req_data[32*mg +: 32];
            p_base  = req_base[mg];
            p_owner = mg;
            pend_at = c + 1;
            mlast   = mg;
            idle_at = c + 1 + D;
         end
      end else if (c >= idle_at && |req_valid) begin
         mg       = rr_next(req_valid, mlast);
         grant_at = c + 1;
         idle_at  = c + 2;
      end
      @(posedge clk);
      c++;
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_num", num_out, 32'd0);
      chk("rst_base", 32'(base_sel), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      c++;
      #1;
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic set_req(input int i, input logic [31:0] d,
                          input logic b);
      req_valid[i] = 1'b1;
      req_data[32*i +: 32] = d;
      req_base[i] = b;
   endtask

   task automatic drive_random();
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i]) begin
            if (req_ready[i]) begin
               if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
               else drop_next[i] = 1'b1;
            end else if (drop_next[i]) begin
               req_valid[i] = 1'b0;
               drop_next[i] = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
               req_valid[i] = 1'b0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            set_req(i, $urandom, 1'($urandom_range(0, 1)));
         end
      end
   endtask

   int gidx[$];
   int gcyc[$];
   int n;

   initial begin
      #1;
      do_reset();
      repeat (8) tick();

      // single request
      do_reset();
      set_req(2, 32'h0000_1234, 1'b1);
      tick();
      chk("t2_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid[2] = 1'b0;
      chk("t2_num", num_out, 32'h1234);
      chk("t2_base", 32'(base_sel), 32'd1);
      chk("t2_owner", 32'(owner), 32'd2);
      repeat (D + 2) tick();

      // all four held valid
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 32'hA0 + i, 1'(i));
      repeat (30) begin
         tick();
         for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) begin
               gidx.push_back(i);
               gcyc.push_back(c);
            end
      end
      req_valid = '0;
      chk("t3_count", 32'(gidx.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < gidx.size(); k++) begin
         chk("t3_order", 32'(gidx[k]), 32'(k % NREQ));
         if (k > 0) chk("t3_space", 32'(gcyc[k] - gcyc[k-1]), 32'(D + 2));
      end
      repeat (D + 2) tick();

      // sole requester
      do_reset();
      set_req(1, 32'hBEEF, 1'b0);
      n = 0;
      repeat (20) begin
         tick();
         if (req_ready != '0) n++;
      end
      chk("t4_grants", 32'(n), 32'd4);
      chk("t4_owner", 32'(owner), 32'd1);
      req_valid = '0;
      repeat (D + 2) tick();

      // valid dropped during grant
      do_reset();
      set_req(1, 32'h55, 1'b0);
      tick();
      tick();
      req_valid[1] = 1'b0;
      repeat (D + 2) tick();
      set_req(3, 32'h77, 1'b1);
      tick();
      req_valid[3] = 1'b0;
      tick();
      chk("t5_num", num_out, 32'h55);
      chk("t5_owner", 32'(owner), 32'd1);
      set_req(0, 32'h10, 1'b0);
      set_req(2, 32'h20, 1'b1);
      tick();
      chk("t5_next", 32'(req_ready), 32'h4);
      tick();
      chk("t5_owner2", 32'(owner), 32'd2);
      req_valid = '0;
      repeat (D + 2) tick();

      // reset two cycles into dwell
      do_reset();
      req_valid = 4'hF;
      repeat (4) tick();
      #2;
      do_reset();
      req_valid = 4'b1010;
      tick();
      chk("t6_first", 32'(req_ready), 32'h2);

      repeat (3000) begin
         drive_random();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Round-robin scheduler that shares the single 8-digit seven-segment display between up to `NREQ` requesters (CPU register, counters, debug taps). Each requester posts a 32-bit value plus a base flag over a valid/ready handshake. The arbiter grants one requester, latches its value, and holds it on the display for a minimum dwell time before re-arbitrating. Its `num_out`/`base_sel` outputs drive the `num_in`/`base_sel` inputs of `seven_segment_switch`.

## Interface
- `NREQ`, 4 — number of requesters, 2..8.
- `DWELL_CYCLES`, 50_000_000 — minimum cycles a granted value stays displayed; must be ≥1.
- `clk` input 1 — system clock.
- `resetn` input 1 — reset; one clock; reset is asynchronous and active-low.
- `req_valid` input NREQ — bit i: requester i has a value pending; held until its `req_ready` pulse.
- `req_data` input NREQ*32 — requester i value in bits [32*i+31:32*i].
- `req_base` input NREQ — bit i: 1 = decimal, 0 = hex.
- `req_ready` output NREQ — registered one-cycle accept pulse, at most one bit set.
- `num_out` output 32 — value to display.
- `base_sel` output 1 — base of the displayed value.
- `owner` output clog2(NREQ) — index of the requester currently displayed.
- `busy` output 1 — high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, GRANT, DWELL. All outputs are registered.
- IDLE, with any `req_valid` set:
  - Pick `g` = first set bit searching upward from `last+1`, wrapping modulo NREQ.
  - Register `g` and go to GRANT.
- IDLE, with no request: stay in IDLE; display keeps its last value.
- GRANT (one cycle):
  - `req_ready[g]`=1.
  - If `req_valid[g]`=1: `num_out`←`req_data[g]`, `base_sel`←`req_base[g]`, `owner`←g, `last`←g, dwell counter ← DWELL_CYCLES−1, go to DWELL.
  - If `req_valid[g]`=0 (protocol violation): no capture, `last` unchanged, go to IDLE.
- DWELL:
  - All requests are ignored; `req_ready`=0.
  - Counter decrements each cycle; at 0, go to IDLE.
- Fairness:
  - A requester that re-asserts immediately is granted again only if no other request is pending.
  - A sole requester is re-granted back-to-back.
- Counter width: clog2(DWELL_CYCLES), minimum 1 bit; no wrap (loaded, then decremented to 0 only).
- Reset, mid-operation or at startup:
  - State IDLE, `req_ready`=0, `num_out`=0, `base_sel`=0, `owner`=0, `busy`=0, counter 0.
  - `last`=NREQ−1, so the first search starts at requester 0.

## Timing
- Request seen in IDLE at cycle t:
  - `req_ready[g]` high during cycle t+1.
  - `num_out`/`base_sel`/`owner` update visible at t+2.
  - `busy` high during t+1 .. t+1+DWELL_CYCLES.
  - IDLE at t+2+DWELL_CYCLES, where the next arbitration is sampled.
- Minimum turnaround: DWELL_CYCLES+2 cycles per grant.
- A `req_valid` that falls during IDLE before sampling is simply not seen; no partial state.
- Simultaneous requests: only one is granted per turnaround, by the round-robin rule.

## Structure
- Shared package:
  - FSM state encoding (IDLE/GRANT/DWELL, 2-bit).
  - Display word width constant `DISP_W`=32.
  - Base encodings `BASE_HEX`=0, `BASE_DEC`=1.
- Sub-module `rr_priority_pick`: combinational; inputs `req` vector and `last` pointer; outputs grant index and `any` flag. Reusable by other shared-resource arbiters.
- Top level: FSM, dwell counter, output registers; instantiated alongside `seven_segment_switch`.

## Test plan
1. Reset, then idle.
   - Stimulus: reset asserted then released; all `req_valid`=0.
   - Expect: `num_out`=0, `base_sel`=0, `owner`=0, `busy`=0, `req_ready`=0 indefinitely.
2. Single request (DWELL_CYCLES=4).
   - Stimulus: `req_valid[2]`=1, data 0x0000_1234, base 1, at cycle t.
   - Expect: `req_ready`=4'b0100 at t+1; `num_out`=0x1234, `base_sel`=1, `owner`=2 at t+2; `busy` falls at t+6.
3. Round-robin with all four requesters held valid.
   - Expect: grants in order 0,1,2,3,0, spaced 6 cycles apart.
   - Expect: each `req_ready` pulse exactly one cycle.
4. Sole requester.
   - Stimulus: only requester 1 continuously valid.
   - Expect: re-granted every 6 cycles; `owner` stays 1.
5. Valid dropped during GRANT.
   - Stimulus: requester 3 drops `req_valid` in the GRANT cycle.
   - Expect: display unchanged; next grant search still starts after the previous `last`.
6. Mid-dwell reset.
   - Stimulus: `resetn` pulsed low 2 cycles into DWELL.
   - Expect: asynchronous clear of all outputs before the next edge; first grant after release goes to the lowest valid index.
